// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared processor constants for the register-bank writeback path.
package regbank_wb_arbiter_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 4;

  // Writeback requester identifiers; also the encoding of the last-grant register.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Bus bundle for the writeback arbiter: two writeback requesters, issue port,
// hazard-check reads, register-bank write port and scoreboard view.
interface regbank_wb_arbiter_if
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REGS = regbank_wb_arbiter_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = regbank_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regbank_wb_arbiter_pkg::ADDR_W
) ();

  logic                a_valid;
  logic                a_ready;
  logic [ADDR_W-1:0]   a_dest;
  logic [DATA_W-1:0]   a_data;

  logic                b_valid;
  logic                b_ready;
  logic [ADDR_W-1:0]   b_dest;
  logic [DATA_W-1:0]   b_data;

  logic                issue_valid;
  logic                issue_ready;
  logic [ADDR_W-1:0]   issue_dest;

  logic [ADDR_W-1:0]   srcadd1;
  logic [ADDR_W-1:0]   srcadd2;
  logic                src1_busy;
  logic                src2_busy;

  logic [ADDR_W-1:0]   wr_dest;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic [NUM_REGS-1:0] busy_vec;

  // Requesters, issue stage and register bank side.
  modport master (
    output a_valid, a_dest, a_data,
    input  a_ready,
    output b_valid, b_dest, b_data,
    input  b_ready,
    output issue_valid, issue_dest,
    input  issue_ready,
    output srcadd1, srcadd2,
    input  src1_busy, src2_busy,
    input  wr_dest, wr_data, wr_en, busy_vec
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_dest, a_data,
    output a_ready,
    input  b_valid, b_dest, b_data,
    output b_ready,
    input  issue_valid, issue_dest,
    output issue_ready,
    input  srcadd1, srcadd2,
    output src1_busy, src2_busy,
    output wr_dest, wr_data, wr_en, busy_vec
  );

endinterface

// File: rtl/regbank_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a last-grant register.
module rr_arbiter2
  import regbank_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,    // bit 0 = A, bit 1 = B
  output logic [1:0] gnt_c   // combinational one-hot grant
);

  req_id_e last_q;
  req_id_e last_d;

  // Last-grant register; B after reset so A wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant from requests and last grant; a grant is always a transfer since ready == grant.
  always_comb begin
    gnt_c  = 2'b00;
    last_d = last_q;
    if (!reset) begin
      if (req[0] && (!req[1] || last_q == REQ_B)) begin
        gnt_c[0] = 1'b1;
      end else if (req[1]) begin
        gnt_c[1] = 1'b1;
      end
    end
    if (gnt_c[0]) begin
      last_d = REQ_A;
    end else if (gnt_c[1]) begin
      last_d = REQ_B;
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the register bank: round-robin between ALU (A) and
// load unit (B), registered write port, and a pending-write scoreboard.
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REGS = regbank_wb_arbiter_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = regbank_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regbank_wb_arbiter_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  regbank_wb_arbiter_if.slave  bus
);

  logic [1:0]          gnt_c;
  logic                xfer_a;
  logic                xfer_b;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_dest_q;
  logic [DATA_W-1:0]   wr_data_q;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.b_valid, bus.a_valid}),
    .gnt_c (gnt_c)
  );

  assign bus.a_ready = gnt_c[0];
  assign bus.b_ready = gnt_c[1];
  assign xfer_a      = bus.a_valid & gnt_c[0];
  assign xfer_b      = bus.b_valid & gnt_c[1];

  // Hazard views read the scoreboard directly; no bypass from the write in flight.
  assign bus.issue_ready = ~busy_q[bus.issue_dest];
  assign bus.src1_busy   = busy_q[bus.srcadd1];
  assign bus.src2_busy   = busy_q[bus.srcadd2];
  assign issue_fire      = bus.issue_valid & bus.issue_ready;

  // Scoreboard next state: writeback clears first, then an accepted issue sets.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (xfer_a) begin
      clr_mask = NUM_REGS'(1) << bus.a_dest;
    end else if (xfer_b) begin
      clr_mask = NUM_REGS'(1) << bus.b_dest;
    end
    if (issue_fire) begin
      set_mask = NUM_REGS'(1) << bus.issue_dest;
    end
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Scoreboard and registered write port; wr_dest/wr_data hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
    end else begin
      busy_q  <= busy_d;
      wr_en_q <= xfer_a | xfer_b;
      if (xfer_a) begin
        wr_dest_q <= bus.a_dest;
        wr_data_q <= bus.a_data;
      end else if (xfer_b) begin
        wr_dest_q <= bus.b_dest;
        wr_data_q <= bus.b_data;
      end
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_dest  = wr_dest_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy_vec = busy_q;

endmodule
